// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with fetch handshake, interrupt latching and a circular return-address stack
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter int RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_ADDR = 32'h8000_0000,
  parameter logic [WIDTH-1:0] ILLOP_ADDR = 32'h8000_0004,
  parameter logic [WIDTH-1:0] XADDR = 32'h8000_0008
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [2:0]       PCSEL,
  input  logic [WIDTH-1:0] JT,
  input  logic [WIDTH-1:0] SextC,
  input  logic             ras_push,
  input  logic             irq,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic [WIDTH-1:0] pc_incr_o,
  output logic [WIDTH-1:0] branch_target_o,
  output logic [WIDTH-1:0] xp_o,
  output logic             irq_taken_o,
  output logic             ras_empty_o,
  output logic             ras_full_o
);
  localparam int AW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] pc, xp, pc_nx, xp_nx, top_val;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [AW-1:0] top, top_nx, wr_idx;
  logic [AW:0] cnt, cnt_nx;
  logic valid, pending, taken, adv, take, illop, pop_ok, do_push;
  assign pc_o = pc;
  assign xp_o = xp;
  assign pc_valid_o = valid;
  assign irq_taken_o = taken;
  assign pc_incr_o = pc + WIDTH'(4);
  assign branch_target_o = pc_incr_o + (SextC << 2);
  assign ras_empty_o = cnt == '0;
  assign ras_full_o = cnt == (AW+1)'(RAS_DEPTH);
  assign top_val = ras[top];
  assign adv = valid & (fetch_ready | (PCSEL != 3'b000));
  assign take = adv & (PCSEL == 3'b000) & ~pc[WIDTH-1] & pending;
  assign illop = (PCSEL == 3'b011) | ((PCSEL == 3'b101) & ras_empty_o);
  assign pop_ok = adv & (PCSEL == 3'b101) & ~ras_empty_o;
  assign do_push = adv & ras_push & ~take;
  assign wr_idx = pop_ok ? top : top + AW'(1);
  assign top_nx = pop_ok ? (do_push ? top : top - AW'(1)) : (do_push ? top + AW'(1) : top);
  assign cnt_nx = pop_ok ? (do_push ? cnt : cnt - 1'b1) : (do_push && !ras_full_o ? cnt + 1'b1 : cnt);
  always_comb begin
    pc_nx = pc;
    xp_nx = xp;
    if (take || PCSEL == 3'b100) begin
      pc_nx = XADDR;
      xp_nx = pc_incr_o;
    end else if (illop) begin
      pc_nx = ILLOP_ADDR;
      xp_nx = pc_incr_o;
    end else begin
      case (PCSEL)
        3'b000: pc_nx = {pc[WIDTH-1], pc_incr_o[WIDTH-2:0]};
        3'b001: pc_nx = {pc[WIDTH-1], branch_target_o[WIDTH-2:0]};
        3'b010: pc_nx = {pc[WIDTH-1] & JT[WIDTH-1], JT[WIDTH-2:0]};
        3'b101: pc_nx = {pc[WIDTH-1] & top_val[WIDTH-1], top_val[WIDTH-2:0]};
        default: pc_nx = RST_ADDR;
      endcase
    end
  end
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pc <= RST_ADDR;
      xp <= '0;
      valid <= 1'b0;
      pending <= 1'b0;
      taken <= 1'b0;
      top <= '0;
      cnt <= '0;
    end else begin
      valid <= 1'b1;
      taken <= take;
      pending <= (pending & ~take) | irq;
      if (adv) begin
        pc <= pc_nx;
        xp <= xp_nx;
        top <= top_nx;
        cnt <= cnt_nx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) ras[wr_idx] <= pc_incr_o;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, hand-written RAS/interrupt sequences and random traffic against a queue-based model
module tb_pc_sequencer;
  localparam logic [31:0] RST = 32'h8000_0000, ILL = 32'h8000_0004, XA = 32'h8000_0008;
  localparam int D = 4;
  logic clk = 1'b0;
  logic RESET_N = 1'b1;
  logic [2:0] PCSEL = '0;
  logic [31:0] JT = '0, SextC = '0;
  logic ras_push = 1'b0, irq = 1'b0, fetch_ready = 1'b0;
  logic [31:0] pc_o, pc_incr_o, branch_target_o, xp_o;
  logic pc_valid_o, irq_taken_o, ras_empty_o, ras_full_o;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_xp;
  logic m_pend, m_valid, m_taken;
  logic [31:0] m_ras[$];
  typedef struct {
    logic [2:0] sel;
    logic [31:0] jt, sx;
    logic push, irq, fr;
    logic [31:0] pc, xp;
    logic empty, taken;
  } vec_t;
  vec_t tbl[24];

  pc_sequencer dut (
    .clk(clk), .RESET_N(RESET_N), .PCSEL(PCSEL), .JT(JT), .SextC(SextC),
    .ras_push(ras_push), .irq(irq), .fetch_ready(fetch_ready),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_incr_o(pc_incr_o),
    .branch_target_o(branch_target_o), .xp_o(xp_o), .irq_taken_o(irq_taken_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = RST; m_xp = '0; m_pend = 1'b0; m_valid = 1'b0; m_taken = 1'b0;
    m_ras.delete();
  endtask

  // Model of one clock edge from the rules: supervisor-bit policy, stack as a bounded queue (newest at back)
  task automatic model_edge();
    logic adv, take;
    logic [31:0] incr, bt, t, npc, nxp;
    if (!RESET_N) begin
      m_reset();
      return;
    end
    adv = m_valid && (fetch_ready || PCSEL != 3'd0);
    take = adv && PCSEL == 3'd0 && !m_pc[31] && m_pend;
    incr = m_pc + 32'd4;
    bt = incr + (SextC << 2);
    npc = m_pc; nxp = m_xp;
    if (adv) begin
      if (take) begin npc = XA; nxp = incr; end
      else case (PCSEL)
        3'd0: npc = {m_pc[31], incr[30:0]};
        3'd1: npc = {m_pc[31], bt[30:0]};
        3'd2: npc = {m_pc[31] & JT[31], JT[30:0]};
        3'd3: begin npc = ILL; nxp = incr; end
        3'd4: begin npc = XA; nxp = incr; end
        3'd5: if (m_ras.size() > 0) begin
                t = m_ras.pop_back();
                npc = {m_pc[31] & t[31], t[30:0]};
              end else begin npc = ILL; nxp = incr; end
        default: npc = RST;
      endcase
      if (ras_push && !take) begin
        m_ras.push_back(incr);
        if (m_ras.size() > D) m_ras.delete(0);
      end
    end
    m_pend = irq || (m_pend && !take);
    m_taken = take;
    m_pc = npc; m_xp = nxp; m_valid = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] incr;
    incr = m_pc + 32'd4;
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, m_valid});
    chk({tag, ".incr"}, pc_incr_o, incr);
    chk({tag, ".btgt"}, branch_target_o, incr + (SextC << 2));
    chk({tag, ".xp"}, xp_o, m_xp);
    chk({tag, ".taken"}, {31'd0, irq_taken_o}, {31'd0, m_taken});
    chk({tag, ".empty"}, {31'd0, ras_empty_o}, {31'd0, m_ras.size() == 0});
    chk({tag, ".full"}, {31'd0, ras_full_o}, {31'd0, m_ras.size() == D});
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic apply(input logic [2:0] s, input logic [31:0] j, input logic [31:0] x,
                       input logic p, input logic i, input logic f, input string tag);
    PCSEL = s; JT = j; SextC = x; ras_push = p; irq = i; fetch_ready = f;
    cyc(tag);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, RST, 32'h0, 1'b1, 1'b0};
    tbl[1]  = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, RST, 32'h0, 1'b1, 1'b0};
    tbl[2]  = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, RST, 32'h0, 1'b1, 1'b0};
    tbl[3]  = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'h0, 1'b1, 1'b0};
    tbl[4]  = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0008, 32'h0, 1'b1, 1'b0};
    tbl[5]  = '{3'd2, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0};
    tbl[6]  = '{3'd1, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'hFC, 32'h0, 1'b1, 1'b0};
    tbl[7]  = '{3'd2, 32'h8000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0};
    tbl[8]  = '{3'd2, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0};
    tbl[9]  = '{3'd2, 32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{3'd2, 32'h500, 32'h0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0};
    tbl[11] = '{3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 1'b0, 1'b0};
    tbl[12] = '{3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0};
    tbl[13] = '{3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ILL, 32'h108, 1'b1, 1'b0};
    tbl[14] = '{3'd2, 32'h300, 32'h0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h108, 1'b1, 1'b0};
    tbl[15] = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h108, 1'b1, 1'b0};
    tbl[16] = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, XA, 32'h304, 1'b1, 1'b1};
    tbl[17] = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, XA, 32'h304, 1'b1, 1'b0};
    tbl[18] = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_000C, 32'h304, 1'b1, 1'b0};
    tbl[19] = '{3'd2, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h304, 1'b1, 1'b0};
    tbl[20] = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, XA, 32'h404, 1'b1, 1'b1};
    tbl[21] = '{3'd2, 32'h600, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h404, 1'b1, 1'b0};
    tbl[22] = '{3'd1, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h614, 32'h404, 1'b1, 1'b0};
    tbl[23] = '{3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, XA, 32'h618, 1'b1, 1'b1};

    m_reset();
    #3 RESET_N = 1'b0;
    #1;
    chk("rst.pc", pc_o, RST);
    chk("rst.valid", {31'd0, pc_valid_o}, 32'd0);
    compare_all("rst");
    @(posedge clk); #1;
    compare_all("rst_hold");
    RESET_N = 1'b1;
    cyc("release");
    chk("release.valid", {31'd0, pc_valid_o}, 32'd1);

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].sel, tbl[i].jt, tbl[i].sx, tbl[i].push, tbl[i].irq, tbl[i].fr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.pc", i), pc_o, tbl[i].pc);
      chk($sformatf("vec%0d.xp", i), xp_o, tbl[i].xp);
      chk($sformatf("vec%0d.empty", i), {31'd0, ras_empty_o}, {31'd0, tbl[i].empty});
      chk($sformatf("vec%0d.taken", i), {31'd0, irq_taken_o}, {31'd0, tbl[i].taken});
    end

    apply(3'd2, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0, "ovf.start");
    for (int i = 1; i <= D + 1; i++)
      apply(3'd2, 32'(i + 1) << 12, 32'h0, 1'b1, 1'b0, 1'b0, $sformatf("ovf.push%0d", i));
    chk("ovf.full", {31'd0, ras_full_o}, 32'd1);
    for (int k = 0; k < D; k++) begin
      apply(3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, $sformatf("ovf.pop%0d", k));
      chk($sformatf("ovf.pop%0d.pc", k), pc_o, (32'(D + 1 - k) << 12) + 32'd4);
    end
    chk("ovf.empty", {31'd0, ras_empty_o}, 32'd1);
    apply(3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "ovf.under");
    chk("ovf.under.pc", pc_o, ILL);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      PCSEL = r < 10 ? 3'd0 : r < 12 ? 3'd1 : r < 14 ? 3'd2 : r < 15 ? 3'd3 :
              r < 16 ? 3'd4 : r < 19 ? 3'd5 : 3'($urandom_range(6, 7));
      JT = $urandom;
      SextC = $urandom;
      ras_push = ($urandom % 3) == 0;
      irq = ($urandom % 8) == 0;
      fetch_ready = ($urandom % 4) != 0;
      if ($urandom % 200 == 0) begin
        #2 RESET_N = 1'b0;
        #1;
        m_reset();
        compare_all("async_rst");
        cyc("rand_rst_hold");
        RESET_N = 1'b1;
      end
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC core's fetch stage, the next generation of the single-width PC register. It holds a WIDTH-bit PC whose MSB is the supervisor bit. It selects the next PC from increment, branch, jump, return-address-stack pop, illegal-op, exception or reset sources. It handshakes with instruction memory so the PC only advances when a fetch is accepted, and it adds interrupt latching and a RAS_DEPTH-entry return-address stack.

## Interface
- WIDTH, 32, PC width; bit WIDTH-1 is the supervisor bit
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)
- RST_ADDR, 32'h8000_0000, PC after reset
- ILLOP_ADDR, 32'h8000_0004, illegal-op / RAS-underflow vector
- XADDR, 32'h8000_0008, interrupt vector
- clk  in  1  global clock, rising edge
- RESET_N  in  1  reset: one clock; reset is asynchronous and active-low
- PCSEL  in  3  000 incr, 001 branch, 010 jump, 011 illop, 100 exception/XADDR, 101 RAS return, 11x reset-vector
- JT  in  WIDTH  jump target
- SextC  in  WIDTH  sign-extended word offset (shifted left 2 internally)
- ras_push  in  1  push pc_incr_o onto the RAS with this advance (call)
- irq  in  1  level interrupt request
- fetch_ready  in  1  instruction memory accepts pc_o
- pc_o  out  WIDTH  current fetch address
- pc_valid_o  out  1  pc_o is a valid fetch request
- pc_incr_o  out  WIDTH  pc_o + 4
- branch_target_o  out  WIDTH  pc_incr_o + (SextC << 2)
- xp_o  out  WIDTH  return address saved on the last interrupt or illop
- irq_taken_o  out  1  one-cycle pulse when an interrupt redirect is taken
- ras_empty_o / ras_full_o  out  1 each  RAS status

## Operation
- Advance: a PC update occurs on an edge only when pc_valid_o && (fetch_ready || PCSEL != 000). Otherwise all state holds (stall).
- PCSEL 000: pc <= {pc[W-1], pc_incr[W-2:0]}. The supervisor bit is never changed by increment; bits wrap within W-1.
- PCSEL 001: pc <= {pc[W-1], branch_target[W-2:0]}.
- PCSEL 010: pc <= {pc[W-1] & JT[W-1], JT[W-2:0]}. A jump may leave supervisor mode but can never enter it.
- PCSEL 011: pc <= ILLOP_ADDR; xp_o <= pc_incr_o.
- PCSEL 100: pc <= XADDR; xp_o <= pc_incr_o.
- PCSEL 101: pop. If not empty, pc <= {pc[W-1] & top[W-1], top[W-2:0]}. If empty, behaves as 011.
- PCSEL 11x: pc <= RST_ADDR.
- Interrupts:
  - irq sets an irq_pending flag, which stays set until taken.
  - Taken on the next advance with PCSEL == 000 and pc[W-1] == 0: pc <= XADDR, xp_o <= pc_incr_o, irq_taken_o = 1 for that cycle, pending cleared.
  - Never taken in supervisor mode.
  - Any PCSEL != 000 has priority over a pending interrupt; pending stays set.
- RAS:
  - Circular buffer with a W-bit entry array, a log2(RAS_DEPTH)-bit top pointer and a count.
  - ras_push is applied only on an advance.
  - Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - Push together with PCSEL 101 pops first, then pushes, so the count is unchanged.
  - A push is ignored when the advance is an interrupt redirect.
- Combinational outputs: pc_incr_o and branch_target_o are always derived from the current pc, with results modulo 2^WIDTH.

## Timing
- Asynchronous assert of RESET_N low forces, immediately:
  - pc_o = RST_ADDR
  - pc_valid_o = 0
  - xp_o = 0
  - irq_taken_o = 0
  - RAS empty (ras_empty_o = 1, ras_full_o = 0)
  - irq_pending = 0
- Release is synchronised by the first rising edge with RESET_N high. pc_valid_o goes 1 on that edge and stays 1; pc_o is still RST_ADDR.
- All PC, xp, RAS and pending updates take effect on the same edge as the advance (one-cycle latency, no bubble).
- irq_taken_o is registered: it is high for exactly the cycle after the redirect edge, during which pc_o == XADDR.
- irq asserted in cycle N is first eligible for the advance at the end of cycle N+1.
- Reset mid-stall or mid-pending discards all state.

## Test plan
- Reset then stall: hold RESET_N low → pc_o = 0x8000_0000 and pc_valid_o = 0. Release, hold fetch_ready = 0 for 3 cycles → pc_o stays 0x8000_0000. Set fetch_ready = 1 → 0x8000_0004, 0x8000_0008.
- Branch: pc = 0x0000_0100, SextC = −2, PCSEL = 001 → pc_o = 0x0000_00FC. Then JT = 0x8000_0040 with PCSEL = 010 from user mode → pc_o = 0x0000_0040 (supervisor not entered).
- RAS call/return:
  - Push at pc 0x100, then at 0x200 → ras_empty_o = 0.
  - PCSEL 101 → pc_o = 0x204; PCSEL 101 again → 0x104.
  - Third pop → pc_o = ILLOP_ADDR and xp_o = 0x108.
- RAS overflow: RAS_DEPTH + 1 pushes at distinct PCs → ras_full_o = 1. RAS_DEPTH pops return the newest RAS_DEPTH addresses in order; the oldest is lost.
- Interrupt:
  - User pc 0x300 with irq pulsed for one cycle → within 2 cycles pc_o = 0x8000_0008, xp_o = 0x304, irq_taken_o pulses once.
  - Same irq in supervisor mode → no redirect until a jump drops to user mode.
- Priority: pending irq with PCSEL = 001 on the same edge → branch taken and irq_taken_o = 0; interrupt taken on the next sequential advance.
